// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: load/run sequencer for the single-clock MIPS IF/ID/EX core.
// Streams a program into the IF instruction memory and holds the core in reset
// while loading. Then it releases the core, runs it, and stops on a halt word
// or on a watchdog expiry.
// Optional feature macro: IMEM_BOOT_SELFLOOP_HALT_EN. When it is defined, RUN
// also halts when PC repeats on consecutive RUN cycles (the `j .` idiom).
module imem_boot_ctrl #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned MAX_CYCLES = 1024,
  parameter logic [31:0] HALT_WORD  = 32'h0000000D
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic [31:0] PC,
  input  logic [31:0] Ins,
  output logic [31:0] W_Ins,
  output logic        WE,
  output logic [31:0] wr_addr,
  output logic        core_rst,
  output logic        run,
  output logic        done,
  output logic        timeout,
  output logic        err,
  output logic [15:0] cycle_count
);

  localparam int unsigned WCNT_W = $clog2(IMEM_WORDS + 1);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 32;

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(IMEM_WORDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_RUN     = 3'd3,
    S_HALT    = 3'd4,
    S_TIMEOUT = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   w_ins_q, w_ins_d;
  logic [DATA_W-1:0]   wr_addr_q, wr_addr_d;
  logic                load_ready_q, load_ready_d;
  logic                core_rst_q, core_rst_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                err_q, err_d;

  logic                xfer_c;
  logic                halt_word_c;
  logic                self_loop_c;
  logic                halt_hit_c;

  // A loader word moves when the controller has advertised ready this cycle.
  assign xfer_c      = load_valid && load_ready_q;
  assign halt_word_c = (Ins == HALT_WORD);

`ifdef IMEM_BOOT_SELFLOOP_HALT_EN
  logic [DATA_W-1:0] prev_pc_q;
  logic              prev_pc_vld_q;

  // Remember last RUN-cycle PC; the valid flag makes the check start on RUN cycle 2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_pc_q     <= '0;
      prev_pc_vld_q <= 1'b0;
    end else begin
      if (state_q == S_RUN) begin
        prev_pc_q <= PC;
      end
      prev_pc_vld_q <= (state_q == S_RUN);
    end
  end

  assign self_loop_c = prev_pc_vld_q && (PC == prev_pc_q);
`else
  logic unused_pc_c;
  assign unused_pc_c = ^PC;
  assign self_loop_c = 1'b0;
`endif

  assign halt_hit_c = halt_word_c || self_loop_c;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      cycle_q      <= '0;
      we_q         <= 1'b0;
      w_ins_q      <= '0;
      wr_addr_q    <= '0;
      load_ready_q <= 1'b0;
      core_rst_q   <= 1'b1;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      cycle_q      <= cycle_d;
      we_q         <= we_d;
      w_ins_q      <= w_ins_d;
      wr_addr_q    <= wr_addr_d;
      load_ready_q <= load_ready_d;
      core_rst_q   <= core_rst_d;
      run_q        <= run_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
    end
  end

  // Next-state, write-port and counter logic. Status outputs follow the next state.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    cycle_d   = cycle_q;
    we_d      = 1'b0;
    w_ins_d   = w_ins_q;
    wr_addr_d = wr_addr_q;

    case (state_q)
      S_IDLE, S_HALT, S_TIMEOUT, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
          cycle_d = '0;
        end
      end

      S_LOAD: begin
        if (xfer_c) begin
          we_d      = 1'b1;
          w_ins_d   = load_data;
          wr_addr_d = DATA_W'(wcnt_q) << 2;
          wcnt_d    = wcnt_q + WCNT_ONE;
          if (load_last) begin
            state_d = S_SETTLE;
          end else if (wcnt_q == WCNT_LAST) begin
            state_d = S_ERR;
          end
        end
      end

      S_SETTLE: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (cycle_q != CNT_SAT) begin
          cycle_d = cycle_q + CNT_ONE;
        end
        if (halt_hit_c) begin
          state_d = S_HALT;
        end else if (cycle_q == CNT_LAST) begin
          state_d = S_TIMEOUT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_ready_d = (state_d == S_LOAD);
    core_rst_d   = !((state_d == S_RUN) || (state_d == S_HALT));
    run_d        = (state_d == S_RUN);
    done_d       = (state_d == S_HALT);
    timeout_d    = (state_d == S_TIMEOUT);
    err_d        = (state_d == S_ERR);
  end

  assign load_ready  = load_ready_q;
  assign W_Ins       = w_ins_q;
  assign WE          = we_q;
  assign wr_addr     = wr_addr_q;
  assign core_rst    = core_rst_q;
  assign run         = run_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign err         = err_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: bench for imem_boot_ctrl with a tiny IF-stage stand-in
// (instruction memory + PC that steps or follows `j`). When the macro
// IMEM_BOOT_SELFLOOP_HALT_EN is defined, the reference model also ends a run
// on a self-loop.
module tb_imem_boot_ctrl;

  localparam int          NW   = 64;
  localparam int          MAXC = 16;
  localparam logic [31:0] HALT = 32'h0000000D;

  localparam int K_DONE    = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_ERR     = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [31:0] PC;
  logic [31:0] Ins;
  logic [31:0] W_Ins;
  logic        WE;
  logic [31:0] wr_addr;
  logic        core_rst;
  logic        run;
  logic        done;
  logic        timeout;
  logic        err;
  logic [15:0] cycle_count;

  imem_boot_ctrl #(
    .IMEM_WORDS(NW),
    .MAX_CYCLES(MAXC),
    .HALT_WORD (HALT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .PC         (PC),
    .Ins        (Ins),
    .W_Ins      (W_Ins),
    .WE         (WE),
    .wr_addr    (wr_addr),
    .core_rst   (core_rst),
    .run        (run),
    .done       (done),
    .timeout    (timeout),
    .err        (err),
    .cycle_count(cycle_count)
  );

  always #5 CLK = ~CLK;

  // IF-stage stand-in: instruction memory written through the write port, PC reset by core_rst.
  logic [31:0] imem [0:63];
  logic [31:0] pc_r;
  logic        mem_clr;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) imem[i] <= 32'h0;
    end else if (WE === 1'b1) begin
      imem[wr_addr[7:2]] <= W_Ins;
    end
  end

  always @(posedge CLK) begin
    if (core_rst !== 1'b0) pc_r <= 32'h0;
    else if (run === 1'b1) pc_r <= (Ins[31:26] == 6'd2) ? {pc_r[31:28], Ins[25:0], 2'b00} : pc_r + 32'd4;
  end

  assign PC  = pc_r;
  assign Ins = imem[pc_r[7:2]];

  // Write-port monitor and core_rst window monitor, sampled mid-cycle.
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          crst_viol = 0;

  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(W_Ins);
    end
    if (core_rst === 1'b0 && !(run === 1'b1 || done === 1'b1)) crst_viol++;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int wbase    = 0;

  typedef struct packed {
    logic        load_ready;
    logic        we;
    logic [31:0] w_ins;
    logic [31:0] wr_addr;
    logic        core_rst;
    logic        run;
    logic        done;
    logic        timeout;
    logic        err;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    logic        rst;
    logic        start;
    logic        lv;
    logic        ll;
    logic [31:0] ld;
    out_t        exp;
    bit          dc;
  } vec_t;

  function automatic out_t mko(input bit rdy, input bit we, input logic [31:0] wi, input logic [31:0] wa,
                               input bit cr, input bit rn, input bit dn, input bit to, input bit er,
                               input logic [15:0] c);
    out_t o;
    o.load_ready = rdy; o.we = we; o.w_ins = wi; o.wr_addr = wa;
    o.core_rst = cr; o.run = rn; o.done = dn; o.timeout = to; o.err = er; o.cnt = c;
    return o;
  endfunction

  function automatic vec_t mkv(input bit r, input bit s, input bit lv, input bit ll, input logic [31:0] ld,
                               input out_t e, input bit dc);
    vec_t v;
    v.rst = r; v.start = s; v.lv = lv; v.ll = ll; v.ld = ld; v.exp = e; v.dc = dc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic cmp_out(input string nm, input out_t e, input bit dc);
    out_t a;
    a = mko(load_ready, WE, W_Ins, wr_addr, core_rst, run, done, timeout, err, cycle_count);
    if (dc) begin
      a.w_ins = '0; a.wr_addr = '0; e.w_ins = '0; e.wr_addr = '0;
    end
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference run: walk the program from PC 0 as the core would, one instruction per RUN cycle.
  function automatic void ref_run(input logic [31:0] p[$], output int kind, output int cnt);
    int          pc;
    int          prev;
    logic [31:0] w;
    pc = 0; prev = 0; cnt = 0; kind = K_TIMEOUT;
    for (int c = 1; c <= MAXC; c++) begin
      w   = (pc / 4 < p.size()) ? p[pc / 4] : 32'h0;
      cnt = c;
      if (w == HALT) begin
        kind = K_DONE;
        return;
      end
`ifdef IMEM_BOOT_SELFLOOP_HALT_EN
      if (c > 1 && pc == prev) begin
        kind = K_DONE;
        return;
      end
`endif
      prev = pc;
      pc   = (w[31:26] == 6'd2) ? int'({4'h0, w[25:0], 2'b00}) : pc + 4;
    end
  endfunction

  task automatic send_word(input string nm, input logic [31:0] d, input bit last, input int gap);
    int g;
    load_valid = 1'b0;
    repeat (gap) tick();
    load_valid = 1'b1; load_data = d; load_last = last;
    g = 0;
    while (load_ready !== 1'b1 && g < 8) begin
      tick();
      g++;
    end
    if (g >= 8) bound_fail({nm, "_ready_wait"});
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic load_prog(input string nm, input logic [31:0] p[$], input bit use_last, input int gap_mode);
    int gap;
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    wbase = wq_addr.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_ready_after_start"}, 32'(load_ready), 32'd1);
    foreach (p[i]) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_word(nm, p[i], use_last && (i == p.size() - 1), gap);
    end
  endtask

  task automatic finish_prog(input string nm, input logic [31:0] p[$], input bit use_last);
    int g;
    int kind;
    int cnt;
    int nwr;
    if (use_last) ref_run(p, kind, cnt);
    else begin
      kind = K_ERR;
      cnt  = 0;
    end
    g = 0;
    while (!(done === 1'b1 || timeout === 1'b1 || err === 1'b1) && g < 100) begin
      tick();
      g++;
    end
    if (g >= 100) bound_fail({nm, "_end_wait"});
    repeat (2) tick();
    nwr = (p.size() < NW) ? p.size() : NW;
    chk({nm, "_nwrites"}, 32'(wq_addr.size() - wbase), 32'(nwr));
    for (int i = 0; i < nwr; i++) begin
      if (wbase + i < wq_addr.size()) begin
        chk($sformatf("%s_addr%0d", nm, i), wq_addr[wbase + i], 32'(i * 4));
        chk($sformatf("%s_data%0d", nm, i), wq_data[wbase + i], p[i]);
      end
    end
    chk({nm, "_status"}, 32'({done, timeout, err}),
        (kind == K_DONE) ? 32'd4 : (kind == K_TIMEOUT) ? 32'd2 : 32'd1);
    chk({nm, "_cycles"}, 32'(cycle_count), 32'(cnt));
    chk({nm, "_run"}, 32'(run), 32'd0);
    chk({nm, "_core_rst"}, 32'(core_rst), (kind == K_DONE) ? 32'd0 : 32'd1);
  endtask

  vec_t        vt[14];
  logic [31:0] p[$];
  logic [31:0] w;
  int          g;

  initial begin
    RST = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0; mem_clr = 1'b1;
    repeat (2) tick();
    mem_clr = 1'b0;

    // Cycle-accurate vectors: reset, 3-word load, run to halt, reload, mid-load reset.
    vt[0]  = mkv(1, 0, 0, 0, 32'h0,        mko(0, 0, 32'h0,        32'h0, 1, 0, 0, 0, 0, 16'd0), 0);
    vt[1]  = mkv(0, 1, 0, 0, 32'h0,        mko(1, 0, 32'h0,        32'h0, 1, 0, 0, 0, 0, 16'd0), 0);
    vt[2]  = mkv(0, 0, 1, 0, 32'h20080005, mko(1, 1, 32'h20080005, 32'h0, 1, 0, 0, 0, 0, 16'd0), 0);
    vt[3]  = mkv(0, 0, 1, 0, 32'h20090003, mko(1, 1, 32'h20090003, 32'h4, 1, 0, 0, 0, 0, 16'd0), 0);
    vt[4]  = mkv(0, 0, 1, 1, 32'h0000000D, mko(0, 1, 32'h0000000D, 32'h8, 1, 0, 0, 0, 0, 16'd0), 0);
    vt[5]  = mkv(0, 0, 0, 0, 32'h0,        mko(0, 0, 32'h0,        32'h0, 0, 1, 0, 0, 0, 16'd0), 1);
    vt[6]  = mkv(0, 0, 0, 0, 32'h0,        mko(0, 0, 32'h0,        32'h0, 0, 1, 0, 0, 0, 16'd1), 1);
    vt[7]  = mkv(0, 0, 0, 0, 32'h0,        mko(0, 0, 32'h0,        32'h0, 0, 1, 0, 0, 0, 16'd2), 1);
    vt[8]  = mkv(0, 0, 0, 0, 32'h0,        mko(0, 0, 32'h0,        32'h0, 0, 0, 1, 0, 0, 16'd3), 1);
    vt[9]  = mkv(0, 0, 0, 0, 32'h0,        mko(0, 0, 32'h0,        32'h0, 0, 0, 1, 0, 0, 16'd3), 1);
    vt[10] = mkv(0, 1, 0, 0, 32'h0,        mko(1, 0, 32'h0,        32'h0, 1, 0, 0, 0, 0, 16'd0), 1);
    vt[11] = mkv(0, 0, 1, 0, 32'h00001234, mko(1, 1, 32'h00001234, 32'h0, 1, 0, 0, 0, 0, 16'd0), 0);
    vt[12] = mkv(1, 0, 1, 0, 32'h00005678, mko(0, 0, 32'h0,        32'h0, 1, 0, 0, 0, 0, 16'd0), 0);
    vt[13] = mkv(0, 0, 1, 0, 32'h00009abc, mko(0, 0, 32'h0,        32'h0, 1, 0, 0, 0, 0, 16'd0), 0);

    foreach (vt[i]) begin
      RST = vt[i].rst; start = vt[i].start; load_valid = vt[i].lv;
      load_last = vt[i].ll; load_data = vt[i].ld;
      tick();
      cmp_out($sformatf("vec%0d", i), vt[i].exp, vt[i].dc);
    end
    RST = 1'b0; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;

    // Toggling valid; start during RUN must be ignored.
    p.delete();
    p.push_back(32'h20080005); p.push_back(32'h20090003);
    p.push_back(32'h01095020); p.push_back(HALT);
    load_prog("toggle", p, 1, 1);
    g = 0;
    while (run !== 1'b1 && g < 10) begin
      tick();
      g++;
    end
    if (g >= 10) bound_fail("toggle_run_wait");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("toggle_start_in_run_run", 32'(run), 32'd1);
    chk("toggle_start_in_run_ready", 32'(load_ready), 32'd0);
    finish_prog("toggle", p, 1);

    // No halt word: watchdog.
    p.delete();
    for (int i = 0; i < 5; i++) p.push_back(32'h20080000 | 32'(i));
    load_prog("wdog", p, 1, 0);
    finish_prog("wdog", p, 1);

    // Overflow: full memory without load_last, then a clean reload.
    p.delete();
    for (int i = 0; i < NW; i++) p.push_back(32'h24000000 | 32'(i));
    load_prog("ovf", p, 0, 0);
    chk("ovf_ready_drop", 32'(load_ready), 32'd0);
    chk("ovf_err_now", 32'(err), 32'd1);
    finish_prog("ovf", p, 0);
    if (wq_addr.size() > 0) chk("ovf_last_addr", wq_addr[wq_addr.size() - 1], 32'd252);
    p.delete();
    p.push_back(32'h20080001); p.push_back(HALT);
    load_prog("reload", p, 1, 0);
    finish_prog("reload", p, 1);

    // Self-loop `j 0`: halts with the macro, watchdog otherwise.
    p.delete();
    p.push_back(32'h08000000);
    load_prog("jself", p, 1, 0);
    finish_prog("jself", p, 1);

    // Reset mid-RUN.
    p.delete();
    p.push_back(32'h20080001); p.push_back(32'h20090002); p.push_back(32'h01095020);
    load_prog("rstrun", p, 1, 0);
    g = 0;
    while (run !== 1'b1 && g < 10) begin
      tick();
      g++;
    end
    if (g >= 10) bound_fail("rstrun_run_wait");
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    cmp_out("rstrun_reset", mko(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 16'd0), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rstrun_idle_start", 32'(load_ready), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;

    // Randomized programs against the reference model.
    for (int t = 0; t < 20; t++) begin
      int len;
      len = int'($urandom_range(1, 10));
      p.delete();
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        if (w[31:26] == 6'd2) w[31:26] = 6'd8;
        p.push_back(w);
      end
      if ($urandom_range(0, 1) == 1) p[$urandom_range(0, len - 1)] = HALT;
      load_prog($sformatf("rnd%0d", t), p, 1, 2);
      finish_prog($sformatf("rnd%0d", t), p, 1);
    end

    chk("core_rst_window", 32'(crst_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
